// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate controller.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        PASSING = 2'd2,
        DENY    = 2'd3
    } gate_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_OPEN_TIMEOUT    = 1000;

    // Two-deep event queue kept as thermometer flags: bit 0 = first level, bit 1 = second level.
    function automatic logic [1:0] pend_next(input logic [1:0] pend, input logic ev, input logic grant);
        int c;
        c = int'(pend[0]) + int'(pend[1]) + int'(ev) - int'(grant);
        return {c >= 2, c >= 1};
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor, status and strobe bundle of the parking gate controller.
// Statistics outputs exist only when PARKING_GATE_STATS_EN is defined.
interface parking_gate_ctrl_if;
    logic arrive_raw;
    logic pass_raw;
    logic exit0_raw;
    logic exit1_raw;
    logic full;
    logic barrier_open;
    logic deny;
    logic in_pulse;
    logic out0_pulse;
    logic out1_pulse;
`ifdef PARKING_GATE_STATS_EN
    logic [15:0] entries_total;
    logic [15:0] denied_total;

    modport master (
        output arrive_raw, pass_raw, exit0_raw, exit1_raw, full,
        input  barrier_open, deny, in_pulse, out0_pulse, out1_pulse,
        input  entries_total, denied_total
    );
    modport slave (
        input  arrive_raw, pass_raw, exit0_raw, exit1_raw, full,
        output barrier_open, deny, in_pulse, out0_pulse, out1_pulse,
        output entries_total, denied_total
    );
`else
    modport master (
        output arrive_raw, pass_raw, exit0_raw, exit1_raw, full,
        input  barrier_open, deny, in_pulse, out0_pulse, out1_pulse
    );
    modport slave (
        input  arrive_raw, pass_raw, exit0_raw, exit1_raw, full,
        output barrier_open, deny, in_pulse, out0_pulse, out1_pulse
    );
`endif
endinterface

// File: rtl/parking_gate_ctrl_debounce.sv
// Level debouncer: filt follows raw only after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       settle;

    assign settle = (raw != filt) && (cnt == 8'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= settle & raw;
            fall <= settle & ~raw;
            if (raw == filt || settle)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;
            if (settle)
                filt <= raw;
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry barrier FSM, exit event capture and strobe arbiter for the occupancy counter.
// Define PARKING_GATE_STATS_EN to add the entries_total / denied_total counters.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int OPEN_TIMEOUT    = DEF_OPEN_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    parking_gate_ctrl_if.slave  gate
);

    logic arrive, pass_rise, pass_fall, exit0_rise, exit1_rise;
    logic unused_arrive_rise, unused_arrive_fall, unused_pass_filt;
    logic unused_exit0_filt, unused_exit0_fall, unused_exit1_filt, unused_exit1_fall;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arrive (
        .clk(clk), .rst(rst), .raw(gate.arrive_raw),
        .filt(arrive), .rise(unused_arrive_rise), .fall(unused_arrive_fall));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pass (
        .clk(clk), .rst(rst), .raw(gate.pass_raw),
        .filt(unused_pass_filt), .rise(pass_rise), .fall(pass_fall));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit0 (
        .clk(clk), .rst(rst), .raw(gate.exit0_raw),
        .filt(unused_exit0_filt), .rise(exit0_rise), .fall(unused_exit0_fall));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit1 (
        .clk(clk), .rst(rst), .raw(gate.exit1_raw),
        .filt(unused_exit1_filt), .rise(exit1_rise), .fall(unused_exit1_fall));

    gate_state_t state, state_n;
    logic [15:0] timer, timer_n;
    logic        in_event;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        in_event = 1'b0;
        case (state)
            IDLE: begin
                if (arrive) begin
                    if (gate.full) begin
                        state_n = DENY;
                    end else begin
                        state_n = OPEN;
                        timer_n = 16'(OPEN_TIMEOUT);
                    end
                end
            end
            OPEN: begin
                if (pass_rise) begin
                    state_n = PASSING;
                    timer_n = '0;
                end else if (timer == 16'd1) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            PASSING: begin
                if (pass_fall) begin
                    state_n  = IDLE;
                    in_event = 1'b1;
                end
            end
            DENY: begin
                if (!arrive || !gate.full)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign gate.barrier_open = (state == OPEN) || (state == PASSING);
    assign gate.deny         = (state == DENY);

    // A strobe is never granted in the cycle right after another one: the counter is level-sensitive.
    logic [1:0] in_pend, out0_pend, out1_pend;
    logic       in_strobe, out0_strobe, out1_strobe;
    logic       busy, grant_in, grant_out0, grant_out1;

    assign busy       = in_strobe | out0_strobe | out1_strobe;
    assign grant_in   = !busy && in_pend[0];
    assign grant_out0 = !busy && !in_pend[0] && out0_pend[0];
    assign grant_out1 = !busy && !in_pend[0] && !out0_pend[0] && out1_pend[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_pend     <= '0;
            out0_pend   <= '0;
            out1_pend   <= '0;
            in_strobe   <= 1'b0;
            out0_strobe <= 1'b0;
            out1_strobe <= 1'b0;
        end else begin
            in_pend     <= pend_next(in_pend, in_event, grant_in);
            out0_pend   <= pend_next(out0_pend, exit0_rise, grant_out0);
            out1_pend   <= pend_next(out1_pend, exit1_rise, grant_out1);
            in_strobe   <= grant_in;
            out0_strobe <= grant_out0;
            out1_strobe <= grant_out1;
        end
    end

    assign gate.in_pulse   = in_strobe;
    assign gate.out0_pulse = out0_strobe;
    assign gate.out1_pulse = out1_strobe;

`ifdef PARKING_GATE_STATS_EN
    logic [15:0] entries_cnt, denied_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_cnt <= '0;
            denied_cnt  <= '0;
        end else begin
            if (in_strobe && entries_cnt != 16'hFFFF)
                entries_cnt <= entries_cnt + 16'd1;
            if (state == IDLE && state_n == DENY && denied_cnt != 16'hFFFF)
                denied_cnt <= denied_cnt + 16'd1;
        end
    end

    assign gate.entries_total = entries_cnt;
    assign gate.denied_total  = denied_cnt;
`endif

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles before a sensor level is accepted (range 1..255).
REQ-002 SHALL have parameter OPEN_TIMEOUT, default 1000: cycles the barrier stays open without a car passing (range 1..65535).
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port arrive_raw, input, 1: entry loop sensor, car waiting at barrier.
REQ-006 SHALL have port pass_raw, input, 1: beam behind barrier, car crossing.
REQ-007 SHALL have port exit0_raw, input, 1: floor-0 exit loop sensor.
REQ-008 SHALL have port exit1_raw, input, 1: floor-1 exit loop sensor.
REQ-009 SHALL have port full, input, 1: lot-full flag from the downstream counter.
REQ-010 SHALL have port barrier_open, output, 1: barrier actuator, 1 = open.
REQ-011 SHALL have port deny, output, 1: "lot full" lamp.
REQ-012 SHALL have ports in_pulse, out0_pulse and out1_pulse, output, 1 each: event strobes to the downstream occupancy counter.

Function
REQ-013 SHALL debounce each raw sensor: the filtered level changes only after the raw input differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-014 SHALL run the entry FSM with states IDLE, OPEN, PASSING and DENY; barrier_open=1 only in OPEN and PASSING, and deny=1 only in DENY.
REQ-015 SHALL transition IDLE->OPEN when arrive is 1 and full is 0, and IDLE->DENY when arrive is 1 and full is 1.
REQ-016 SHALL transition DENY->IDLE when arrive falls or full falls, so a full lot clearing re-evaluates the waiting car on the next cycle.
REQ-017 SHALL, in OPEN, load and decrement a 16-bit timer; on pass rising go to PASSING; on timer reaching 0 go to IDLE and record no event.
REQ-018 SHALL, in PASSING, go to IDLE on pass falling and set in_pending; the timer does not run in PASSING.
REQ-019 SHALL set out0_pending and out1_pending on the rising edge of filtered exit0 and exit1 respectively.
REQ-020 SHALL assert each strobe high for exactly one cycle, with at most one strobe high per cycle.
REQ-021 SHALL always follow a strobe cycle with at least one cycle in which all strobes are low, because the downstream counter is level-sensitive.
REQ-022 SHALL arbitrate pending events with fixed priority in > out0 > out1; the pending flag clears on the cycle its strobe is issued.
REQ-023 SHALL not lose a new rising edge that arrives while the same pending flag is still set; it is held in a second-level flag, giving at most 2 queued events per source.
REQ-024 SHALL let the exit paths operate independently of the entry FSM state.

Reset
REQ-025 SHALL, while rst is 1, force FSM=IDLE, barrier_open=0, deny=0, all strobes 0, pending flags 0, timer 0, and filtered sensors 0 with their counts at 0.
REQ-026 SHALL, on reset during OPEN or PASSING, close the barrier immediately and record no entry event.

Configuration
REQ-027 SHALL, with PARKING_GATE_STATS_EN defined, add outputs entries_total[15:0] and denied_total[15:0]: saturating counts of in_pulse strobes and IDLE->DENY transitions, reset to 0.
REQ-028 SHALL, without PARKING_GATE_STATS_EN, have neither those ports nor their logic.

Structure
REQ-029 SHALL take the gate_state_t enum (IDLE, OPEN, PASSING, DENY) and the default DEBOUNCE_CYCLES and OPEN_TIMEOUT constants from the shared package parking_pkg.
REQ-030 SHALL instantiate sub-module sensor_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, filt, rise, fall) four times.

Verification (DEBOUNCE_CYCLES=4, OPEN_TIMEOUT=20)
REQ-031 SHALL cover: arrive pulse of 3 cycles with full=0 -> barrier_open stays 0 and no strobe.
REQ-032 SHALL cover: arrive held 10 cycles with full=0, then pass high 6 cycles then low -> barrier_open from 4 cycles after arrive rises until pass falls is filtered, then one in_pulse.
REQ-033 SHALL cover: arrive held with full=1 -> deny=1 and barrier closed; drop full -> deny=0 the next cycle, then barrier_open=1.
REQ-034 SHALL cover: OPEN with no pass for 20 cycles -> barrier_open=0, FSM IDLE, and no in_pulse.
REQ-035 SHALL cover: completed entry, exit0 and exit1 filtered edges in the same cycle -> in, out0 and out1 strobes in that order, each 1 cycle, separated by 1 low cycle.
REQ-036 SHALL cover: rst asserted mid-PASSING -> barrier_open=0 immediately, and after release no in_pulse is issued.
